// File: rtl/tiny_riscv_mem_arbiter.sv
// Two-port read arbiter for tiny_riscv_memory: one access in flight, round-robin or fixed priority.
// Latency handshake->rsp_valid = READ_LATENCY+2; ready held low whenever an access is in flight.
module tiny_riscv_mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 1,
  parameter int FIXED_PRIO   = 0
) (
  input  logic              i_Clk,
  input  logic              i_Rst,
  input  logic              i_req0_valid,
  input  logic [ADDR_W-1:0] i_req0_addr,
  output logic              o_req0_ready,
  output logic              o_rsp0_valid,
  output logic [DATA_W-1:0] o_rsp0_data,
  input  logic              i_req1_valid,
  input  logic [ADDR_W-1:0] i_req1_addr,
  output logic              o_req1_ready,
  output logic              o_rsp1_valid,
  output logic [DATA_W-1:0] o_rsp1_data,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_read_strobe,
  input  logic [DATA_W-1:0] i_mem_data,
  output logic              o_busy,
  output logic              o_grant
);

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(READ_LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             rr_ptr;
  logic [CNT_W-1:0] lat_cnt;
  logic             win0;
  logic             win1;
  logic             grant_en;

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    win0              = 1'b0;
    win1              = 1'b0;
    grant_en          = 1'b0;
    o_req0_ready      = 1'b0;
    o_req1_ready      = 1'b0;
    o_mem_read_strobe = 1'b0;
    o_rsp0_valid      = 1'b0;
    o_rsp1_valid      = 1'b0;
    o_busy            = 1'b0;
    state_nxt         = state;

    // On a tie the round-robin pointer names the winner; fixed mode favours port 0.
    if (FIXED_PRIO != 0) begin
      win0 = i_req0_valid;
      win1 = i_req1_valid & ~i_req0_valid;
    end else begin
      win0 = i_req0_valid & (~i_req1_valid | ~rr_ptr);
      win1 = i_req1_valid & (~i_req0_valid | rr_ptr);
    end

    grant_en     = (state == ST_IDLE) & ~i_Rst;
    o_req0_ready = grant_en & win0;
    o_req1_ready = grant_en & win1;

    case (state)
      ST_IDLE: begin
        if (o_req0_ready || o_req1_ready) begin
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        o_mem_read_strobe = 1'b1;
        o_busy            = 1'b1;
        state_nxt         = ST_WAIT;
      end
      ST_WAIT: begin
        o_busy = 1'b1;
        if (lat_cnt == '0) begin
          state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        o_busy       = 1'b1;
        o_rsp0_valid = ~o_grant;
        o_rsp1_valid = o_grant;
        state_nxt    = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      o_mem_addr  <= '0;
      o_grant     <= 1'b0;
      rr_ptr      <= 1'b0;
      lat_cnt     <= '0;
      o_rsp0_data <= '0;
      o_rsp1_data <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (o_req0_ready) begin
            o_mem_addr <= i_req0_addr;
            o_grant    <= 1'b0;
            rr_ptr     <= 1'b1;
          end else if (o_req1_ready) begin
            o_mem_addr <= i_req1_addr;
            o_grant    <= 1'b1;
            rr_ptr     <= 1'b0;
          end
        end
        ST_ISSUE: begin
          lat_cnt <= LAT_LOAD;
        end
        ST_WAIT: begin
          // Memory data is registered here so nothing downstream sees it combinationally.
          if (lat_cnt == '0) begin
            if (o_grant) begin
              o_rsp1_data <= i_mem_data;
            end else begin
              o_rsp0_data <= i_mem_data;
            end
          end else begin
            lat_cnt <= lat_cnt - CNT_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
